// File: rtl/ccie_rd_arbiter_pkg.sv
// Shared constants for the CCI-E read arbiter: requester IDs and FSM encoding.
package ccie_pkg;

    localparam int REQ_VEC1 = 0;
    localparam int REQ_VEC2 = 1;
    localparam int REQ_ACCU = 2;
    localparam int NUM_REQ  = 3;
    localparam int ID_W     = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // One-hot grant to requester ID; a zero vector maps to 0 and is never used as a winner.
    function automatic logic [ID_W-1:0] onehot_to_id(input logic [NUM_REQ-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        if (oh[REQ_VEC2]) id = 2'd1;
        if (oh[REQ_ACCU]) id = 2'd2;
        return id;
    endfunction

endpackage

// File: rtl/ccie_rd_arbiter_rr_arb3.sv
// Combinational 3-way round-robin select; search order rr_ptr, rr_ptr+1, rr_ptr+2.
module rr_arb3
    import ccie_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic [1:0]         rr_ptr,
    output logic [NUM_REQ-1:0] grant
);

    // First valid requester at or after the pointer wins.
    always_comb begin
        grant = '0;
        case (rr_ptr)
            2'd1: begin
                if      (valid[1]) grant = 3'b010;
                else if (valid[2]) grant = 3'b100;
                else if (valid[0]) grant = 3'b001;
            end
            2'd2: begin
                if      (valid[2]) grant = 3'b100;
                else if (valid[0]) grant = 3'b001;
                else if (valid[1]) grant = 3'b010;
            end
            default: begin
                if      (valid[0]) grant = 3'b001;
                else if (valid[1]) grant = 3'b010;
                else if (valid[2]) grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/ccie_rd_arbiter.sv
// Shares the CCI-E read channel between the vec1, vec2 and accumulate readers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | disabled, nothing in flight
// ST_RUN   | granting requests (subject to credit and back-pressure)
// ST_DRAIN | disabled, waiting for outstanding responses to return
module ccie_rd_arbiter
    import ccie_pkg::*;
#(
    parameter int ADDR_LMT        = 20,
    parameter int MDATA           = 14,
    parameter int CACHE_WIDTH     = 512,
    parameter int MAX_OUTSTANDING = 32,
    localparam int OW             = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_LMT-1:0] req_addr,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [ADDR_LMT-1:0]         rd_req_addr,
    output logic [MDATA-1:0]            rd_req_mdata,
    output logic                        rd_req_en,
    input  logic                        rd_req_almostfull,
    input  logic                        rd_rsp_valid,
    input  logic [MDATA-1:0]            rd_rsp_mdata,
    input  logic [CACHE_WIDTH-1:0]      rd_rsp_data,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [CACHE_WIDTH-1:0]      rsp_data,
    output logic [OW-1:0]               outstanding,
    output logic                        idle,
    output logic                        tag_err
);

    localparam int SEQ_W = MDATA - ID_W;

    logic [1:0]                      state_q, state_d;
    logic [1:0]                      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0][SEQ_W-1:0]   seq_q, seq_d;
    logic                            rd_req_en_q, rd_req_en_d;
    logic [ADDR_LMT-1:0]             rd_req_addr_q, rd_req_addr_d;
    logic [MDATA-1:0]                rd_req_mdata_q, rd_req_mdata_d;
    logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
    logic [CACHE_WIDTH-1:0]          rsp_data_q, rsp_data_d;
    logic [OW-1:0]                   outstanding_q, outstanding_d;
    logic                            tag_err_q, tag_err_d;

    logic [NUM_REQ-1:0]                arb_grant;
    logic [NUM_REQ-1:0][ADDR_LMT-1:0]  addr_arr;
    logic                              grant_ok;
    logic                              xfer;
    logic                              rsp_dec;
    logic [ID_W-1:0]                   win_id;
    logic [ID_W-1:0]                   rsp_id;

    rr_arb3 u_rr_arb3 (
        .valid  (req_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (arb_grant)
    );

    assign addr_arr  = req_addr;
    assign grant_ok  = (state_q == ST_RUN) && enable && !rd_req_almostfull &&
                       (outstanding_q < OW'(MAX_OUTSTANDING));
    assign req_ready = grant_ok ? arb_grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign win_id    = onehot_to_id(req_ready);
    assign rsp_id    = rd_rsp_mdata[MDATA-1 -: ID_W];
    // A response with nothing in flight must not wrap the counter below zero.
    assign rsp_dec   = rd_rsp_valid && (outstanding_q != '0);

    // Request stage: latch the winner's address and tag, advance pointer and sequence.
    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        seq_d          = seq_q;
        rd_req_en_d    = xfer;
        rd_req_addr_d  = rd_req_addr_q;
        rd_req_mdata_d = rd_req_mdata_q;
        if (xfer) begin
            rr_ptr_d       = (win_id == 2'd2) ? 2'd0 : win_id + 2'd1;
            seq_d[win_id]  = seq_q[win_id] + SEQ_W'(1);
            rd_req_addr_d  = addr_arr[win_id];
            rd_req_mdata_d = {win_id, seq_q[win_id]};
        end
    end

    // Response routing, tag error detection and the in-flight counter.
    always_comb begin
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        tag_err_d     = tag_err_q;
        outstanding_d = outstanding_q;
        if (rd_rsp_valid) begin
            rsp_data_d = rd_rsp_data;
            if (rsp_id == 2'd3) tag_err_d = 1'b1;
            else                rsp_valid_d[rsp_id] = 1'b1;
            if (outstanding_q == '0) tag_err_d = 1'b1;
        end
        case ({xfer, rsp_dec})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Enable/drain sequencing; re-enable takes priority over finishing a drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN: begin
                if (!enable) state_d = (outstanding_q != '0) ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (enable)                    state_d = ST_RUN;
                else if (outstanding_q == '0)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All arbiter state, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            seq_q          <= '0;
            rd_req_en_q    <= 1'b0;
            rd_req_addr_q  <= '0;
            rd_req_mdata_q <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            outstanding_q  <= '0;
            tag_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            seq_q          <= seq_d;
            rd_req_en_q    <= rd_req_en_d;
            rd_req_addr_q  <= rd_req_addr_d;
            rd_req_mdata_q <= rd_req_mdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            outstanding_q  <= outstanding_d;
            tag_err_q      <= tag_err_d;
        end
    end

    assign rd_req_en    = rd_req_en_q;
    assign rd_req_addr  = rd_req_addr_q;
    assign rd_req_mdata = rd_req_mdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign outstanding  = outstanding_q;
    assign tag_err      = tag_err_q;
    assign idle         = (state_q == ST_IDLE);

endmodule

// File: tb/tb_ccie_rd_arbiter.sv
// Directed bench for ccie_rd_arbiter: arbitration order, credits, back-pressure,
// response routing, drain and asynchronous reset.
module tb_ccie_rd_arbiter;

    localparam int AL = 20;
    localparam int MD = 14;
    localparam int CW = 32;
    localparam int MO = 8;
    localparam int OW = $clog2(MO) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            enable = 1'b0;
    logic [2:0]      req_valid = '0;
    logic [3*AL-1:0] req_addr = '0;
    logic [2:0]      req_ready;
    logic [AL-1:0]   rd_req_addr;
    logic [MD-1:0]   rd_req_mdata;
    logic            rd_req_en;
    logic            rd_req_almostfull = 1'b0;
    logic            rd_rsp_valid = 1'b0;
    logic [MD-1:0]   rd_rsp_mdata = '0;
    logic [CW-1:0]   rd_rsp_data = '0;
    logic [2:0]      rsp_valid;
    logic [CW-1:0]   rsp_data;
    logic [OW-1:0]   outstanding;
    logic            idle;
    logic            tag_err;

    int n_assert = 0;
    int n_fail   = 0;

    ccie_rd_arbiter #(
        .ADDR_LMT        (AL),
        .MDATA           (MD),
        .CACHE_WIDTH     (CW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_ready         (req_ready),
        .rd_req_addr       (rd_req_addr),
        .rd_req_mdata      (rd_req_mdata),
        .rd_req_en         (rd_req_en),
        .rd_req_almostfull (rd_req_almostfull),
        .rd_rsp_valid      (rd_rsp_valid),
        .rd_rsp_mdata      (rd_rsp_mdata),
        .rd_rsp_data       (rd_rsp_data),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .outstanding       (outstanding),
        .idle              (idle),
        .tag_err           (tag_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MD-1:0] md(input int id, input int seq);
        return MD'((id << (MD - 2)) | seq);
    endfunction

    initial begin
        req_addr = {20'h00030, 20'h00020, 20'h00010};

        // Reset values
        #1 rst = 1'b1;
        #1;
        chk("rst_req_en", 64'(rd_req_en), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_tag_err", 64'(tag_err), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Round robin with all three requesters valid
        enable = 1'b1;
        req_valid = 3'b111;
        #1 chk("idle_no_grant", 64'(req_ready), 64'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("rr_ready", 64'(req_ready), 64'(3'b001 << (i % 3)));
            tick();
            chk("rr_req_en", 64'(rd_req_en), 64'd1);
            chk("rr_addr", 64'(rd_req_addr), 64'(((i % 3) + 1) * 16));
            chk("rr_mdata", 64'(rd_req_mdata), 64'(md(i % 3, i / 3)));
        end
        req_valid = 3'b000;
        tick();
        chk("rr_req_en_off", 64'(rd_req_en), 64'd0);
        chk("rr_outstanding", 64'(outstanding), 64'd6);

        // Back-pressure holds grants and the pointer
        rd_req_almostfull = 1'b1;
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            #1 chk("af_ready", 64'(req_ready), 64'd0);
            tick();
            chk("af_req_en", 64'(rd_req_en), 64'd0);
        end
        rd_req_almostfull = 1'b0;
        #1 chk("af_resume_ready", 64'(req_ready), 64'(3'b001));
        tick();
        req_valid = 3'b000;
        chk("af_resume_en", 64'(rd_req_en), 64'd1);
        chk("af_resume_addr", 64'(rd_req_addr), 64'h10);
        chk("af_resume_mdata", 64'(rd_req_mdata), 64'(md(0, 2)));
        chk("af_outstanding", 64'(outstanding), 64'd7);

        // Response routing by tag ID
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = md(2, 5);  rd_rsp_data = 32'hA2A2_0002;
        tick();
        chk("rsp2_valid", 64'(rsp_valid), 64'(3'b100));
        chk("rsp2_data", 64'(rsp_data), 64'hA2A2_0002);
        chk("rsp2_out", 64'(outstanding), 64'd6);
        rd_rsp_mdata = md(0, 1);  rd_rsp_data = 32'hA0A0_0000;
        tick();
        chk("rsp0_valid", 64'(rsp_valid), 64'(3'b001));
        chk("rsp0_data", 64'(rsp_data), 64'hA0A0_0000);
        chk("rsp0_out", 64'(outstanding), 64'd5);
        rd_rsp_mdata = md(1, 0);  rd_rsp_data = 32'hA1A1_0001;
        tick();
        chk("rsp1_valid", 64'(rsp_valid), 64'(3'b010));
        chk("rsp1_data", 64'(rsp_data), 64'hA1A1_0001);
        chk("rsp1_out", 64'(outstanding), 64'd4);
        rd_rsp_mdata = md(3, 0);  rd_rsp_data = 32'hBAD0_0003;
        tick();
        chk("rsp3_valid", 64'(rsp_valid), 64'd0);
        chk("rsp3_tag_err", 64'(tag_err), 64'd1);
        chk("rsp3_out", 64'(outstanding), 64'd3);
        rd_rsp_valid = 1'b0;
        tick();
        chk("rsp_off_valid", 64'(rsp_valid), 64'd0);
        chk("tag_err_sticky", 64'(tag_err), 64'd1);

        // Simultaneous transfer and response at outstanding=5
        req_valid = 3'b001;
        tick();
        tick();
        chk("pre_same_out", 64'(outstanding), 64'd5);
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = md(0, 0);
        rd_rsp_data  = 32'h5A5A_5A5A;
        #1 chk("same_ready", 64'(req_ready), 64'(3'b001));
        tick();
        rd_rsp_valid = 1'b0;
        chk("same_out", 64'(outstanding), 64'd5);
        chk("same_req_en", 64'(rd_req_en), 64'd1);
        chk("same_mdata", 64'(rd_req_mdata), 64'(md(0, 5)));
        chk("same_rsp_valid", 64'(rsp_valid), 64'(3'b001));

        // Credit limit at MAX_OUTSTANDING
        tick();
        tick();
        tick();
        chk("lim_out", 64'(outstanding), 64'd8);
        chk("lim_ready", 64'(req_ready), 64'd0);
        tick();
        chk("lim_req_en", 64'(rd_req_en), 64'd0);
        chk("lim_out_hold", 64'(outstanding), 64'd8);
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = md(1, 1);
        rd_rsp_data  = 32'h0000_1111;
        #1 chk("lim_ready_rsp", 64'(req_ready), 64'd0);
        tick();
        rd_rsp_valid = 1'b0;
        chk("lim_out_dec", 64'(outstanding), 64'd7);
        chk("lim_rsp_valid", 64'(rsp_valid), 64'(3'b010));
        #1 chk("lim_ready_again", 64'(req_ready), 64'(3'b001));
        tick();
        req_valid = 3'b000;
        chk("lim_regrant_en", 64'(rd_req_en), 64'd1);
        chk("lim_regrant_mdata", 64'(rd_req_mdata), 64'(md(0, 9)));
        chk("lim_regrant_out", 64'(outstanding), 64'd8);

        // Drain
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = md(0, 0);
        for (int i = 0; i < 6; i++) tick();
        rd_rsp_valid = 1'b0;
        chk("drain_pre_out", 64'(outstanding), 64'd2);
        enable = 1'b0;
        req_valid = 3'b111;
        tick();
        chk("drain_idle", 64'(idle), 64'd0);
        chk("drain_no_grant", 64'(req_ready), 64'd0);
        rd_rsp_valid = 1'b1;
        tick();
        tick();
        rd_rsp_valid = 1'b0;
        chk("drain_out0", 64'(outstanding), 64'd0);
        tick();
        chk("drain_done_idle", 64'(idle), 64'd1);
        req_valid = 3'b000;

        // Asynchronous reset mid-stream
        enable = 1'b1;
        req_valid = 3'b001;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("mid_out", 64'(outstanding), 64'd7);
        chk("mid_req_en", 64'(rd_req_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req_en", 64'(rd_req_en), 64'd0);
        chk("arst_addr", 64'(rd_req_addr), 64'd0);
        chk("arst_mdata", 64'(rd_req_mdata), 64'd0);
        chk("arst_out", 64'(outstanding), 64'd0);
        chk("arst_tag_err", 64'(tag_err), 64'd0);
        chk("arst_idle", 64'(idle), 64'd1);
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst_rsp_data", 64'(rsp_data), 64'd0);
        chk("arst_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;
        enable = 1'b0;
        req_valid = 3'b000;

        // Late response after reset counts as underflow
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = md(0, 0);
        tick();
        rd_rsp_valid = 1'b0;
        chk("uflow_tag_err", 64'(tag_err), 64'd1);
        chk("uflow_out", 64'(outstanding), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
